// File: rtl/corelet_ctrl.sv
// Tile-level instruction sequencer for the corelet: SRAM fetch, L0/IFIFO fill,
// execute, drain and readout in weight-stationary or output-stationary mode.
module corelet_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int len_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_sel,
  input  logic [len_bw-1:0] num_act,
  input  logic              acc_en,
  input  logic              c_ready,
  input  logic              c_valid,
  output logic [7:0]        inst,
  output logic              mode,
  output logic              output_en,
  output logic              mem_rd,
  output logic [len_bw-1:0] mem_addr,
  output logic              busy,
  output logic              done
);

  // The counter must reach the longest phase, the drain timeout of row+col+N.
  localparam int CW = $clog2(row + col + (1 << len_bw));
  localparam int AW = CW + 1;

  localparam logic [CW-1:0] ROW_C    = CW'(row);
  localparam logic [CW-1:0] ROW_M1   = CW'(row - 1);
  localparam logic [CW-1:0] COL_M1   = CW'(col - 1);
  localparam logic [CW-1:0] RC_M1    = CW'(row + col - 1);
  localparam logic [AW-1:0] ADDR_MAX = AW'((1 << len_bw) - 1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_W_LOAD   = 4'd1;
  localparam logic [3:0] S_W_KERNEL = 4'd2;
  localparam logic [3:0] S_W_SETTLE = 4'd3;
  localparam logic [3:0] S_A_LOAD   = 4'd4;
  localparam logic [3:0] S_A_EXEC   = 4'd5;
  localparam logic [3:0] S_DRAIN    = 4'd6;
  localparam logic [3:0] S_READ     = 4'd7;
  localparam logic [3:0] S_O_LOAD   = 4'd8;
  localparam logic [3:0] S_O_EXEC   = 4'd9;
  localparam logic [3:0] S_O_SETTLE = 4'd10;
  localparam logic [3:0] S_O_OUT    = 4'd11;
  localparam logic [3:0] S_DONE     = 4'd12;

  logic [3:0]        state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_step, cnt_next;
  logic [CW-1:0]     n_cur;
  logic [len_bw-1:0] n_reg;
  logic              acc_reg, mode_reg;

  logic [7:0]        inst_reg, inst_next;
  logic              output_en_reg, output_en_next;
  logic              mem_rd_reg, mem_rd_next;
  logic [len_bw-1:0] mem_addr_reg, mem_addr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              is_load, issue, rd_issue;
  logic [CW-1:0]     base;
  logic [AW-1:0]     addr_sum;

  // On the start edge the tile length has not been latched yet.
  assign n_cur = CW'((state_reg == S_IDLE) ? num_act : n_reg);

  // Phase sequencing. Cycle phases count cycles; load and read phases count
  // issued transfers, which the output decode below advances.
  always_comb begin
    state_next = state_reg;
    cnt_step   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_step = '0;
        if (start) begin
          if (num_act == '0)  state_next = S_DONE;
          else if (mode_sel)  state_next = S_O_LOAD;
          else                state_next = S_W_LOAD;
        end
      end
      S_W_LOAD: begin
        if (cnt_reg == ROW_C && !mem_rd_reg) begin
          state_next = S_W_KERNEL;
          cnt_step   = '0;
        end
      end
      S_W_KERNEL: begin
        if (cnt_reg == ROW_M1) begin
          state_next = S_W_SETTLE;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_W_SETTLE: begin
        if (cnt_reg == COL_M1) begin
          state_next = S_A_LOAD;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_A_LOAD: begin
        if (cnt_reg == n_cur && !mem_rd_reg) begin
          state_next = S_A_EXEC;
          cnt_step   = '0;
        end
      end
      S_A_EXEC: begin
        if (cnt_reg == n_cur - 1'b1) begin
          state_next = S_DRAIN;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_DRAIN: begin
        if (c_valid || cnt_reg == RC_M1 + n_cur) begin
          state_next = S_READ;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_reg == n_cur) begin
          state_next = S_DONE;
          cnt_step   = '0;
        end
      end
      S_O_LOAD: begin
        if (cnt_reg == n_cur && !mem_rd_reg) begin
          state_next = S_O_EXEC;
          cnt_step   = '0;
        end
      end
      S_O_EXEC: begin
        if (cnt_reg == n_cur - 1'b1) begin
          state_next = S_O_SETTLE;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_O_SETTLE: begin
        if (cnt_reg == RC_M1) begin
          state_next = S_O_OUT;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_O_OUT: begin
        if (cnt_reg == ROW_M1) begin
          state_next = S_DONE;
          cnt_step   = '0;
        end else begin
          cnt_step = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        cnt_step   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_step   = '0;
      end
    endcase
  end

  // Output decode for the cycle about to start, so every output is a flop.
  always_comb begin
    cnt_next       = cnt_step;
    inst_next      = '0;
    output_en_next = 1'b0;
    mem_rd_next    = 1'b0;
    mem_addr_next  = '0;
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_DONE);
    issue          = 1'b0;
    rd_issue       = 1'b0;
    base           = '0;

    // FIFO writes trail the SRAM read by its one-cycle latency.
    inst_next[2] = mem_rd_reg;
    inst_next[5] = mem_rd_reg & mode_reg;

    is_load = (state_next == S_W_LOAD) || (state_next == S_A_LOAD) ||
              (state_next == S_O_LOAD);

    case (state_next)
      S_W_LOAD:   issue = (cnt_step < ROW_C);
      S_A_LOAD: begin
        issue = (cnt_step < n_cur) && c_ready;
        base  = ROW_C;
      end
      S_O_LOAD:   issue = (cnt_step < n_cur);
      S_W_KERNEL: begin
        inst_next[3] = 1'b1;
        inst_next[0] = 1'b1;
      end
      S_A_EXEC: begin
        inst_next[3] = 1'b1;
        inst_next[1] = 1'b1;
      end
      S_O_EXEC: begin
        inst_next[4] = 1'b1;
        inst_next[3] = 1'b1;
        inst_next[1] = 1'b1;
      end
      S_READ: begin
        rd_issue     = c_valid && (cnt_step < n_cur);
        inst_next[6] = rd_issue;
        inst_next[7] = rd_issue & acc_reg;
        cnt_next     = cnt_step + CW'(rd_issue);
      end
      S_O_OUT:    output_en_next = 1'b1;
      default:    ;
    endcase

    // A stalled load keeps presenting the next address to be read.
    addr_sum = {1'b0, base} + {1'b0, cnt_step};
    if (is_load) begin
      mem_rd_next   = issue;
      mem_addr_next = (addr_sum > ADDR_MAX) ? '1 : addr_sum[len_bw-1:0];
      cnt_next      = cnt_step + CW'(issue);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      n_reg         <= '0;
      acc_reg       <= 1'b0;
      mode_reg      <= 1'b0;
      inst_reg      <= '0;
      output_en_reg <= 1'b0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      inst_reg      <= inst_next;
      output_en_reg <= output_en_next;
      mem_rd_reg    <= mem_rd_next;
      mem_addr_reg  <= mem_addr_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      if (state_reg == S_IDLE && start) begin
        n_reg    <= num_act;
        acc_reg  <= acc_en;
        mode_reg <= mode_sel;
      end
    end
  end

  assign inst      = inst_reg;
  assign mode      = mode_reg;
  assign output_en = output_en_reg;
  assign mem_rd    = mem_rd_reg;
  assign mem_addr  = mem_addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  a_cnt_no_wrap: assert property (@(posedge clk) disable iff (reset)
    !((state_next == state_reg) && (cnt_reg == '1) && (cnt_next == '0)));

endmodule
